// File: rtl/seg_scan_drv.sv
// rtl/seg_scan_drv.sv - six-digit multiplexed seven-segment scan driver
//
// Purpose:
//    Time-multiplexes six BCD digits (HH:MM:SS) onto a common-cathode style
//    seven-segment bus. Every scan tick alternates between an anti-ghost
//    blank slot and a lit slot for the next digit, so one frame is 12 ticks.
//    The six digits are captured into a snapshot once per frame so a frame
//    never mixes old and new time values.
//
// Ports:
//    CLK              clock, rising edge
//    RESET            asynchronous, active-high reset
//    ENABLE           scan enable; low blanks display and parks at frame start
//    SEC1..HOUR10     BCD digit inputs (4 bits each)
//    COLON            lights DP on digits 2 and 4
//    LZB              blanks HOUR10 when it is zero
//    BLINK            blink phase; high blanks digits selected by MASK
//    MASK[5:0]        per-digit blink select
//    AN[5:0]          digit select, one-hot active-low (AN[0]=SEC1 .. AN[5]=HOUR10)
//    SEG[6:0]         segments a..g, active-high
//    DP               decimal point, active-high

module seg_scan_drv #(
   parameter int DIV = 1000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic [3:0] SEC1,
   input  logic [3:0] SEC10,
   input  logic [3:0] MIN1,
   input  logic [3:0] MIN10,
   input  logic [3:0] HOUR1,
   input  logic [3:0] HOUR10,
   input  logic       COLON,
   input  logic       LZB,
   input  logic       BLINK,
   input  logic [5:0] MASK,
   output logic [5:0] AN,
   output logic [6:0] SEG,
   output logic       DP
);

   localparam int             CW      = $clog2(DIV);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   state_t          state;
   logic [2:0]      idx;
   logic [CW-1:0]   cnt;
   logic [5:0][3:0] snap;
   logic [5:0][3:0] live;

   logic            tick;
   logic [3:0]      cur_digit;
   logic            blinked;
   logic [6:0]      show_seg;
   logic            show_dp;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    bcd_to_seg = 7'h3F;
         4'd1:    bcd_to_seg = 7'h06;
         4'd2:    bcd_to_seg = 7'h5B;
         4'd3:    bcd_to_seg = 7'h4F;
         4'd4:    bcd_to_seg = 7'h66;
         4'd5:    bcd_to_seg = 7'h6D;
         4'd6:    bcd_to_seg = 7'h7D;
         4'd7:    bcd_to_seg = 7'h07;
         4'd8:    bcd_to_seg = 7'h7F;
         4'd9:    bcd_to_seg = 7'h6F;
         default: bcd_to_seg = 7'h40;   // non-BCD shows a dash
      endcase
   endfunction

   assign live = {HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1};
   assign tick = ENABLE && (cnt == CNT_MAX);

   // Segment/DP pattern for the digit about to be lit (BLANK(idx) -> SHOW(idx)).
   // Blink wins over leading-zero blanking, which wins over the decoder.
   always_comb begin
      cur_digit = snap[idx];
      blinked   = BLINK && MASK[idx];
      show_seg  = 7'h00;
      if (!blinked) begin
         if (idx == 3'd5 && LZB && cur_digit == 4'd0) begin
            show_seg = 7'h00;
         end else begin
            show_seg = bcd_to_seg(cur_digit);
         end
      end
      show_dp = COLON && !blinked && (idx == 3'd2 || idx == 3'd4);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt   <= '0;
         state <= BLANK;
         idx   <= 3'd0;
         snap  <= '0;
         AN    <= 6'h3F;
         SEG   <= 7'h00;
         DP    <= 1'b0;
      end else if (!ENABLE) begin
         // Parked at frame start; snapshot tracks the inputs so the first
         // frame after enable shows the latest values.
         cnt   <= '0;
         state <= BLANK;
         idx   <= 3'd0;
         snap  <= live;
         AN    <= 6'h3F;
         SEG   <= 7'h00;
         DP    <= 1'b0;
      end else if (tick) begin
         cnt <= '0;
         case (state)
            BLANK: begin
               state <= SHOW;
               AN    <= ~(6'd1 << idx);
               SEG   <= show_seg;
               DP    <= show_dp;
            end
            SHOW: begin
               state <= BLANK;
               AN    <= 6'h3F;
               SEG   <= 7'h00;
               DP    <= 1'b0;
               if (idx == 3'd5) begin
                  idx  <= 3'd0;
                  snap <= live;   // only frame boundary refreshes the snapshot
               end else begin
                  idx <= idx + 3'd1;
               end
            end
            default: begin
               state <= BLANK;
               idx   <= 3'd0;
               AN    <= 6'h3F;
               SEG   <= 7'h00;
               DP    <= 1'b0;
            end
         endcase
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_drv.sv
// tb/tb_seg_scan_drv.sv - scoreboard bench for seg_scan_drv

module tb_seg_scan_drv;

   localparam int DIV = 2;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       ENABLE = 1'b0;
   logic [3:0] SEC1 = 4'd0, SEC10 = 4'd0, MIN1 = 4'd0, MIN10 = 4'd0, HOUR1 = 4'd0, HOUR10 = 4'd0;
   logic       COLON = 1'b0, LZB = 1'b0, BLINK = 1'b0;
   logic [5:0] MASK = 6'd0;
   logic [5:0] AN;
   logic [6:0] SEG;
   logic       DP;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   seg_scan_drv #(.DIV(DIV)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
      .SEC1(SEC1), .SEC10(SEC10), .MIN1(MIN1), .MIN10(MIN10), .HOUR1(HOUR1), .HOUR10(HOUR10),
      .COLON(COLON), .LZB(LZB), .BLINK(BLINK), .MASK(MASK),
      .AN(AN), .SEG(SEG), .DP(DP)
   );

   typedef struct packed {
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
   } out_t;

   localparam out_t BLANK_OUT = '{an: 6'h3F, seg: 7'h00, dp: 1'b0};

   out_t exp_q[$];
   out_t m_out = '{an: 6'h3F, seg: 7'h00, dp: 1'b0};
   out_t mon_e;
   int   m_k = 0;
   int   m_slot;
   int   m_i;
   logic [3:0] m_snap [6] = '{default: 4'd0};
   logic [3:0] m_d;

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      logic [6:0] tab [10];
      tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      if (d > 4'd9) return 7'h40;
      return tab[d];
   endfunction

   // Reference model: m_k counts enabled edges since the frame start; the
   // slot number k/DIV alternates blank (even) and lit digit slot/2 (odd).
   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         m_k = 0;
         for (int j = 0; j < 6; j++) m_snap[j] = 4'd0;
         m_out = BLANK_OUT;
         exp_q.delete();
      end else begin
         if (!ENABLE) begin
            m_k = 0;
            m_snap = '{SEC1, SEC10, MIN1, MIN10, HOUR1, HOUR10};
            m_out = BLANK_OUT;
         end else begin
            m_k = m_k + 1;
            if (m_k == 12 * DIV) begin
               m_k = 0;
               m_snap = '{SEC1, SEC10, MIN1, MIN10, HOUR1, HOUR10};
            end
            if (m_k % DIV == 0) begin
               m_slot = m_k / DIV;
               if (m_slot % 2 == 1) begin
                  m_i = m_slot / 2;
                  m_d = m_snap[m_i];
                  m_out.an = 6'h3F ^ (6'd1 << m_i);
                  if (BLINK && MASK[m_i]) begin
                     m_out.seg = 7'h00;
                     m_out.dp  = 1'b0;
                  end else begin
                     m_out.seg = (m_i == 5 && LZB && m_d == 4'd0) ? 7'h00 : ref_seg(m_d);
                     m_out.dp  = COLON && (m_i == 2 || m_i == 4);
                  end
               end else begin
                  m_out = BLANK_OUT;
               end
            end
         end
         exp_q.push_back(m_out);
      end
   end

   // Monitor: every cycle the DUT presents a registered output word.
   always @(negedge CLK) begin
      if (!RESET && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if ({AN, SEG, DP} !== mon_e) begin
            failures++;
            $display("FAIL scan_out t=%0t got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     $time, AN, SEG, DP, mon_e.an, mon_e.seg, mon_e.dp);
         end
      end
   end

   task automatic check_out(input string name, input logic [5:0] an_e, input logic [6:0] seg_e, input logic dp_e);
      checks++;
      if (AN !== an_e || SEG !== seg_e || DP !== dp_e) begin
         failures++;
         $display("FAIL %s got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                  name, AN, SEG, DP, an_e, seg_e, dp_e);
      end
   endtask

   // Wait for the next blank, then for digit i to light; check its pattern.
   task automatic show_check(input string name, input int i, input logic [6:0] seg_e, input logic dp_e);
      logic [5:0] target;
      int n;
      target = 6'h3F ^ (6'd1 << i);
      n = 0;
      while (AN !== 6'h3F && n < 200) begin @(negedge CLK); n++; end
      while (AN !== target && n < 200) begin @(negedge CLK); n++; end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL %s timeout waiting for an=%h got an=%h", name, target, AN);
      end else begin
         check_out(name, target, seg_e, dp_e);
      end
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog expired got t=%0t expected finish", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1 RESET = 1'b1;
      #1 check_out("reset_outputs", 6'h3F, 7'h00, 1'b0);
      {HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
      ENABLE = 1'b1;
      repeat (3) @(negedge CLK);
      #1 RESET = 1'b0;

      // First frame shows the zero snapshot.
      show_check("frame1_d0", 0, 7'h3F, 1'b0);
      show_check("frame1_d5", 5, 7'h3F, 1'b0);

      // Second frame shows 12:34:56; MIN1 changes mid-frame.
      show_check("frame2_d0", 0, 7'h7D, 1'b0);
      show_check("frame2_d1", 1, 7'h6D, 1'b0);
      MIN1 = 4'd9;
      show_check("tear_d2_old", 2, 7'h66, 1'b0);
      show_check("frame2_d3", 3, 7'h4F, 1'b0);
      show_check("frame2_d4", 4, 7'h5B, 1'b0);
      show_check("frame2_d5", 5, 7'h06, 1'b0);
      show_check("tear_d2_new", 2, 7'h6F, 1'b0);

      // Decode boundaries.
      SEC1 = 4'hA; HOUR10 = 4'd0; LZB = 1'b1;
      show_check("frame3_d5", 5, 7'h06, 1'b0);
      show_check("dash_d0", 0, 7'h40, 1'b0);
      show_check("lzb_on_d5", 5, 7'h00, 1'b0);
      LZB = 1'b0;
      show_check("lzb_off_d5", 5, 7'h3F, 1'b0);

      // Colon and blink.
      COLON = 1'b1; BLINK = 1'b1; MASK = 6'b000100;
      show_check("blink_d2", 2, 7'h00, 1'b0);
      show_check("colon_d4", 4, 7'h5B, 1'b1);
      BLINK = 1'b0;
      show_check("colon_d2", 2, 7'h6F, 1'b1);

      // Asynchronous reset mid SHOW(3).
      show_check("pre_reset_d3", 3, 7'h4F, 1'b0);
      #1 RESET = 1'b1;
      #1 check_out("reset_mid_show", 6'h3F, 7'h00, 1'b0);
      COLON = 1'b0;
      repeat (2) @(negedge CLK);
      #1 RESET = 1'b0;

      // Enable dropped during SHOW(3) for 5 cycles.
      show_check("post_reset_d3", 3, 7'h3F, 1'b0);
      ENABLE = 1'b0;
      @(negedge CLK);
      check_out("disable_blank", 6'h3F, 7'h00, 1'b0);
      SEC1 = 4'd7;
      repeat (4) @(negedge CLK);
      ENABLE = 1'b1;
      @(negedge CLK);
      check_out("enable_edge1", 6'h3F, 7'h00, 1'b0);
      @(negedge CLK);
      check_out("enable_edge2", 6'h3E, 7'h07, 1'b0);

      // Randomised phase; the scoreboard checks every cycle.
      for (int it = 0; it < 1500; it++) begin
         @(negedge CLK);
         if ($urandom_range(0, 7) == 0) SEC1   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) SEC10  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) MIN1   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) MIN10  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) HOUR1  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) HOUR10 = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) COLON  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) LZB    = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) BLINK  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) MASK   = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 59) == 0) begin
            ENABLE = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge CLK);
            ENABLE = 1'b1;
         end
      end

      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
